ir_queue: RTL and testbench

//  Parametrised instruction register/prefetch queue; successor to the single-entry IR.

---
 rtl/ir_queue_pkg.sv | 15 +
 rtl/ir_queue_ptr.sv | 38 +++
 rtl/ir_queue.sv | 108 ++++++++++
 tb/tb_ir_queue.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ir_queue_pkg.sv
// Shared constants, types and helpers for the instruction prefetch queue.
// Consumers import this with ir_queue_pkg::*.
package ir_queue_pkg;

    localparam int IRQ_DEPTH = 4;
    localparam int INSTR_W   = 16;

    typedef logic [INSTR_W-1:0] instr_t;

    // Width of an occupancy counter that must represent 0..depth inclusive
    function automatic int irq_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ir_queue_ptr.sv
// Wrap-around pointer register for the instruction queue.
// clr has priority over inc.
module ir_queue_ptr
    import ir_queue_pkg::*;
#(
    parameter int DEPTH = IRQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       inc,
    output logic [$clog2(DEPTH)-1:0]   ptr
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/ir_queue.sv
// Instruction prefetch queue between fetch and decode: circular buffer with a separate count.
// Optional same-cycle pass-through when empty is enabled by defining IR_QUEUE_BYPASS_EN.
module ir_queue
    import ir_queue_pkg::*;
#(
    parameter int DATA_W = INSTR_W,
    parameter int DEPTH  = IRQ_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          il_in,
    input  logic [DATA_W-1:0]             ins_in,
    input  logic                          ack_in,
    input  logic                          flush_in,
    output logic [DATA_W-1:0]             ins_out,
    output logic                          valid_out,
    output logic                          full_out,
    output logic [irq_cnt_w(DEPTH)-1:0]   count_out,
    output logic                          ovf_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = irq_cnt_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              empty, full, byp, byp_take, pop_mem, push;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

`ifdef IR_QUEUE_BYPASS_EN
    assign byp = empty && il_in && !flush_in && !rst;
`else
    assign byp = 1'b0;
`endif

    // A bypassed word that is acked in the same cycle is consumed and never stored
    assign byp_take = byp && ack_in;
    assign pop_mem  = ack_in && !empty;
    assign push     = il_in && (!full || pop_mem) && !byp_take && !flush_in;

    ir_queue_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush_in),
        .inc (push),
        .ptr (wr_ptr)
    );

    ir_queue_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush_in),
        .inc (pop_mem),
        .ptr (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (flush_in) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case ({push, pop_mem})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (il_in && full && !pop_mem) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr] <= ins_in;
        end
    end

    assign valid_out = !empty || byp;
    assign ins_out   = !empty ? mem_q[rd_ptr] : (byp ? ins_in : '0);
    assign full_out  = full;
    assign count_out = count_q;
    assign ovf_out   = ovf_q;

    a_full_count : assert property (@(posedge clk) disable iff (rst)
        full_out |-> (count_out == CNT_W'(DEPTH)));
    a_empty_zero : assert property (@(posedge clk) disable iff (rst)
        !valid_out |-> (ins_out == '0));
    a_count_max  : assert property (@(posedge clk) disable iff (rst)
        count_out <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_ir_queue.sv
// Scoreboard bench for ir_queue: reset, fill/drain, overflow, full push+pop, flush, bypass, random traffic.
module tb_ir_queue;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
`ifdef IR_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          il_in = 1'b0;
    logic [DW-1:0] ins_in = '0;
    logic          ack_in = 1'b0;
    logic          flush_in = 1'b0;
    logic [DW-1:0] ins_out;
    logic          valid_out;
    logic          full_out;
    logic [CW-1:0] count_out;
    logic          ovf_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_w;

    ir_queue #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .il_in     (il_in),
        .ins_in    (ins_in),
        .ack_in    (ack_in),
        .flush_in  (flush_in),
        .ins_out   (ins_out),
        .valid_out (valid_out),
        .full_out  (full_out),
        .count_out (count_out),
        .ovf_out   (ovf_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        il_in = 1'b0; ack_in = 1'b0; flush_in = 1'b0; ins_in = '0;
    endtask

    task automatic do_flush();
        idle(); flush_in = 1'b1; tick(); flush_in = 1'b0;
        sb.delete();
    endtask

    task automatic fill(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            il_in = 1'b1; ins_in = base + DW'(i); ack_in = 1'b0;
            tick();
            sb.push_back(base + DW'(i));
        end
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1; il_in = 1'b1; ins_in = 16'hABCD;
        tick(); tick();
        n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", valid_out); end
        n_tests++; if (count_out !== '0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", count_out); end
        n_tests++; if (ins_out !== 16'h0000) begin n_fail++; $display("FAIL reset_ins: got %h exp 0000", ins_out); end
        n_tests++; if (ovf_out !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b exp 0", ovf_out); end
        n_tests++; if (full_out !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b exp 0", full_out); end
        rst = 1'b0; idle();
        sb.delete();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            il_in = 1'b1; ins_in = 16'h1001 + DW'(i);
            tick();
            sb.push_back(16'h1001 + DW'(i));
            n_tests++; if (count_out !== CW'(i + 1)) begin n_fail++; $display("FAIL fill_count: got %0d exp %0d", count_out, i + 1); end
            n_tests++; if (ins_out !== 16'h1001) begin n_fail++; $display("FAIL fill_head: got %h exp 1001", ins_out); end
        end
        idle();
        n_tests++; if (full_out !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b exp 1", full_out); end
        for (int i = 0; i < DEPTH; i++) begin
            ack_in = 1'b1; #1;
            exp_w = sb.pop_front();
            n_tests++; if (ins_out !== exp_w || valid_out !== 1'b1) begin n_fail++; $display("FAIL drain_word: got %h/%b exp %h/1", ins_out, valid_out, exp_w); end
            tick();
        end
        idle(); #1;
        n_tests++; if (valid_out !== 1'b0 || ins_out !== '0) begin n_fail++; $display("FAIL drain_empty: got %h/%b exp 0000/0", ins_out, valid_out); end
        n_tests++; if (count_out !== '0) begin n_fail++; $display("FAIL drain_count: got %0d exp 0", count_out); end
    endtask

    task automatic test_overflow();
        fill(16'h1001, DEPTH);
        il_in = 1'b1; ins_in = 16'hDEAD; ack_in = 1'b0;
        tick(); idle();
        n_tests++; if (count_out !== CW'(DEPTH)) begin n_fail++; $display("FAIL ovf_count: got %0d exp %0d", count_out, DEPTH); end
        n_tests++; if (ovf_out !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b exp 1", ovf_out); end
        for (int i = 0; i < DEPTH; i++) begin
            ack_in = 1'b1; #1;
            exp_w = sb.pop_front();
            n_tests++; if (ins_out !== exp_w || ins_out === 16'hDEAD) begin n_fail++; $display("FAIL ovf_drain: got %h exp %h", ins_out, exp_w); end
            tick();
        end
        idle(); #1;
        n_tests++; if (valid_out !== 1'b0 || ovf_out !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got valid %b ovf %b exp 0/1", valid_out, ovf_out); end
        do_flush();
        n_tests++; if (ovf_out !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b exp 0", ovf_out); end
    endtask

    task automatic test_full_push_pop();
        fill(16'h1001, DEPTH);
        il_in = 1'b1; ins_in = 16'h2005; ack_in = 1'b1; #1;
        n_tests++; if (ins_out !== 16'h1001) begin n_fail++; $display("FAIL fpp_head0: got %h exp 1001", ins_out); end
        tick(); idle();
        void'(sb.pop_front()); sb.push_back(16'h2005);
        n_tests++; if (count_out !== CW'(DEPTH) || ins_out !== 16'h1002) begin n_fail++; $display("FAIL fpp_state: got %0d/%h exp %0d/1002", count_out, ins_out, DEPTH); end
        n_tests++; if (ovf_out !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf: got %b exp 0", ovf_out); end
        for (int i = 0; i < DEPTH; i++) begin
            ack_in = 1'b1; #1;
            exp_w = sb.pop_front();
            n_tests++; if (ins_out !== exp_w) begin n_fail++; $display("FAIL fpp_drain: got %h exp %h", ins_out, exp_w); end
            tick();
        end
        idle(); #1;
        n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL fpp_empty: got %b exp 0", valid_out); end
    endtask

    task automatic test_flush();
        fill(16'h5001, 3);
        n_tests++; if (count_out !== CW'(3)) begin n_fail++; $display("FAIL flush_pre: got %0d exp 3", count_out); end
        flush_in = 1'b1; il_in = 1'b1; ins_in = 16'h3333; ack_in = 1'b1;
        tick(); idle();
        sb.delete();
        n_tests++; if (count_out !== '0 || valid_out !== 1'b0 || ovf_out !== 1'b0) begin n_fail++; $display("FAIL flush_state: got cnt %0d v %b ovf %b exp 0/0/0", count_out, valid_out, ovf_out); end
        tick();
        n_tests++; if (ins_out === 16'h3333 || valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got %h/%b exp 0000/0", ins_out, valid_out); end
    endtask

    task automatic test_bypass();
        il_in = 1'b1; ins_in = 16'h4242; ack_in = 1'b1; #1;
        n_tests++; if (valid_out !== BYP) begin n_fail++; $display("FAIL byp_valid: got %b exp %b", valid_out, BYP); end
        n_tests++; if (ins_out !== (BYP ? 16'h4242 : 16'h0000)) begin n_fail++; $display("FAIL byp_ins: got %h exp %h", ins_out, BYP ? 16'h4242 : 16'h0000); end
        tick(); idle();
        n_tests++; if (count_out !== (BYP ? CW'(0) : CW'(1))) begin n_fail++; $display("FAIL byp_count: got %0d exp %0d", count_out, BYP ? 0 : 1); end
        do_flush();
    endtask

    task automatic test_back_to_back();
        logic il, ack, pop, take, push, exp_ovf;
        logic [DW-1:0] din, exp_ins;
        exp_ovf = 1'b0;
        for (int c = 0; c < 300; c++) begin
            il = ($urandom_range(0, 99) < 60); ack = ($urandom_range(0, 99) < 45);
            din = DW'($urandom);
            il_in = il; ack_in = ack; ins_in = din; #1;
            exp_ins = (sb.size() != 0) ? sb[0] : ((BYP && il) ? din : '0);
            n_tests++; if (valid_out !== ((sb.size() != 0) || (BYP && il)) || ins_out !== exp_ins) begin n_fail++; $display("FAIL b2b_out: cyc %0d got %h/%b exp %h", c, ins_out, valid_out, exp_ins); end
            pop  = ack && (sb.size() != 0);
            take = BYP && (sb.size() == 0) && il && ack;
            push = il && (sb.size() < DEPTH || pop) && !take;
            if (il && sb.size() == DEPTH && !pop) exp_ovf = 1'b1;
            tick();
            if (pop)  void'(sb.pop_front());
            if (push) sb.push_back(din);
            n_tests++; if (count_out !== CW'(sb.size()) || ovf_out !== exp_ovf) begin n_fail++; $display("FAIL b2b_state: cyc %0d got %0d/%b exp %0d/%b", c, count_out, ovf_out, sb.size(), exp_ovf); end
        end
        idle();
        do_flush();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_bypass();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
